// File: rtl/pp_sample_sched_pkg.sv
// Shared types and defaults for the ping-pong sample scheduler.
package pp_sample_sched_pkg;

  localparam int unsigned AW_DEF = 12;
  localparam int unsigned NW_DEF = 16;

  typedef enum logic [1:0] {
    BANK_EMPTY = 2'd0,
    BANK_FULL  = 2'd1,
    BANK_DONE  = 2'd2
  } bank_st_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sched_st_e;

endpackage

// File: rtl/pp_word_cnt.sv
// Word counter with terminal-count compare; wraps to 0 on the terminal increment.
module pp_word_cnt #(
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic [AW-1:0] last,
  output logic [AW-1:0] cnt,
  output logic          tc_c
);

  assign tc_c = (cnt == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= tc_c ? '0 : cnt + AW'(1);
    end
  end

endmodule

// File: rtl/pp_sample_sched.sv
// Ping-pong scheduler: overlaps fill, exec and drain of the two src/dst sample banks.
module pp_sample_sched
  import pp_sample_sched_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned NW = NW_DEF
) (
  input  logic          AXIS_ACLK,
  input  logic          AXIS_ARESETN,
  input  logic          clr,
  input  logic          start,
  input  logic [NW-1:0] nsample,
  input  logic [AW-1:0] ss,
  input  logic [AW-1:0] ds,
  input  logic          src_valid,
  output logic          src_ready,
  output logic          src_v,
  output logic [AW-1:0] src_a,
  output logic          inp,
  output logic          s_init,
  input  logic          s_fin,
  output logic          execp,
  output logic          dst_valid,
  input  logic          dst_ready,
  output logic          dst_v,
  output logic [AW-1:0] dst_a,
  output logic          dst_last,
  output logic          outp,
  output logic          busy,
  output logic          done
);

  sched_st_e     state_q, state_n;
  bank_st_e      bank_q [2];
  bank_st_e      bank_n [2];
  logic          inp_n, execp_n, outp_n;
  logic          exec_busy_q, exec_busy_n;
  logic          s_init_n, src_ready_n, dst_valid_n, busy_n, done_n;
  logic [NW-1:0] fills_left_q, fills_left_n;
  logic [NW-1:0] drained_q, drained_n;
  logic [NW-1:0] nsample_q, nsample_n;
  logic [AW-1:0] ss_m1_q, ss_m1_n;
  logic [AW-1:0] ds_m1_q, ds_m1_n;
  logic          src_tc, dst_tc;
  logic          fill_end, drain_end;

  assign src_v     = src_valid & src_ready;
  assign dst_v     = dst_valid & dst_ready;
  assign dst_last  = dst_valid & dst_tc;
  assign fill_end  = src_v & src_tc;
  assign drain_end = dst_v & dst_tc;

  // ss/ds of 0 give a last index of all-ones, i.e. a full 2^AW-word sample.
  pp_word_cnt #(.AW(AW)) u_fill_cnt (
    .clk   (AXIS_ACLK),
    .rst_n (AXIS_ARESETN),
    .clr   (clr),
    .inc   (src_v),
    .last  (ss_m1_q),
    .cnt   (src_a),
    .tc_c  (src_tc)
  );

  pp_word_cnt #(.AW(AW)) u_drain_cnt (
    .clk   (AXIS_ACLK),
    .rst_n (AXIS_ARESETN),
    .clr   (clr),
    .inc   (dst_v),
    .last  (ds_m1_q),
    .cnt   (dst_a),
    .tc_c  (dst_tc)
  );

  // Next-state: each engine only touches a bank in its own source state, so no conflicts.
  always_comb begin
    state_n      = state_q;
    bank_n       = bank_q;
    inp_n        = inp;
    execp_n      = execp;
    outp_n       = outp;
    exec_busy_n  = exec_busy_q;
    fills_left_n = fills_left_q;
    drained_n    = drained_q;
    nsample_n    = nsample_q;
    ss_m1_n      = ss_m1_q;
    ds_m1_n      = ds_m1_q;
    busy_n       = busy;
    done_n       = 1'b0;
    s_init_n     = 1'b0;

    if (clr) begin
      state_n      = ST_IDLE;
      bank_n[0]    = BANK_EMPTY;
      bank_n[1]    = BANK_EMPTY;
      inp_n        = 1'b0;
      execp_n      = 1'b0;
      outp_n       = 1'b0;
      exec_busy_n  = 1'b0;
      fills_left_n = '0;
      drained_n    = '0;
      nsample_n    = '0;
      ss_m1_n      = '0;
      ds_m1_n      = '0;
      busy_n       = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (nsample == '0) begin
              done_n = 1'b1;
            end else begin
              state_n      = ST_RUN;
              busy_n       = 1'b1;
              nsample_n    = nsample;
              fills_left_n = nsample;
              drained_n    = '0;
              ss_m1_n      = ss - AW'(1);
              ds_m1_n      = ds - AW'(1);
            end
          end
        end
        ST_RUN: begin
          if (fill_end) begin
            bank_n[inp]  = BANK_FULL;
            inp_n        = ~inp;
            fills_left_n = fills_left_q - NW'(1);
          end
          if (exec_busy_q && s_fin) begin
            bank_n[execp] = BANK_DONE;
            execp_n       = ~execp;
            exec_busy_n   = 1'b0;
          end else if (!exec_busy_q && (bank_q[execp] == BANK_FULL)) begin
            s_init_n    = 1'b1;
            exec_busy_n = 1'b1;
          end
          if (drain_end) begin
            bank_n[outp] = BANK_EMPTY;
            outp_n       = ~outp;
            drained_n    = drained_q + NW'(1);
            if ((drained_q + NW'(1)) == nsample_q) begin
              state_n = ST_IDLE;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end

    // Handshake enables are registered from next state; nothing depends on src_valid.
    src_ready_n = (state_n == ST_RUN) && (fills_left_n != '0) && (bank_n[inp_n] == BANK_EMPTY);
    dst_valid_n = (state_n == ST_RUN) && (bank_n[outp_n] == BANK_DONE);
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q      <= ST_IDLE;
      bank_q[0]    <= BANK_EMPTY;
      bank_q[1]    <= BANK_EMPTY;
      inp          <= 1'b0;
      execp        <= 1'b0;
      outp         <= 1'b0;
      exec_busy_q  <= 1'b0;
      fills_left_q <= '0;
      drained_q    <= '0;
      nsample_q    <= '0;
      ss_m1_q      <= '0;
      ds_m1_q      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      s_init       <= 1'b0;
      src_ready    <= 1'b0;
      dst_valid    <= 1'b0;
    end else begin
      state_q      <= state_n;
      bank_q[0]    <= bank_n[0];
      bank_q[1]    <= bank_n[1];
      inp          <= inp_n;
      execp        <= execp_n;
      outp         <= outp_n;
      exec_busy_q  <= exec_busy_n;
      fills_left_q <= fills_left_n;
      drained_q    <= drained_n;
      nsample_q    <= nsample_n;
      ss_m1_q      <= ss_m1_n;
      ds_m1_q      <= ds_m1_n;
      busy         <= busy_n;
      done         <= done_n;
      s_init       <= s_init_n;
      src_ready    <= src_ready_n;
      dst_valid    <= dst_valid_n;
    end
  end

endmodule
